// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer: state encoding and default tick count.
// State bit [1] is the debounced level, so db comes straight off a flop.
package debounce_pkg;

  localparam int N_TICKS_DEF = 3;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b11,
    WAIT0 = 2'b10
  } db_state_t;

  function automatic logic state_level(input db_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/debounce_fsm_if.sv
// Tick/switch inputs and debounced outputs of debounce_fsm.
// Edge-pulse signals exist only when DEBOUNCE_EDGE_EN is defined.
interface debounce_fsm_if;

  logic tick;
  logic sw;
  logic db;
`ifdef DEBOUNCE_EDGE_EN
  logic db_rise;
  logic db_fall;

  modport master (output tick, output sw, input db, input db_rise, input db_fall);
  modport slave  (input tick, input sw, output db, output db_rise, output db_fall);
`else
  modport master (output tick, output sw, input db);
  modport slave  (input tick, input sw, output db);
`endif

endinterface

// File: rtl/debounce_fsm_sync_2ff.sv
// Two-flop synchroniser for an asynchronous board input; reusable for any
// single-bit level that crosses into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_fsm.sv
// Tick-driven switch debouncer: sw must stay stable for N_TICKS ticks before db follows.
// Define DEBOUNCE_EDGE_EN to add registered db_rise/db_fall pulses.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter  int N_TICKS = N_TICKS_DEF,
  localparam int CW      = $clog2(N_TICKS + 1)
) (
  input logic           clk,
  input logic           reset,
  debounce_fsm_if.slave bus_if
);

  localparam logic [CW-1:0] CNT_LAST = CW'(N_TICKS - 1);

  logic          sw_s;
  db_state_t     state_q;
  logic [CW-1:0] cnt_q;
`ifdef DEBOUNCE_EDGE_EN
  logic          rise_q;
  logic          fall_q;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus_if.sw),
    .q_o   (sw_s)
  );

  // A returning sw_s aborts a wait before any tick is considered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        ZERO: begin
          if (sw_s) begin
            state_q <= WAIT1;
            cnt_q   <= '0;
          end
        end
        WAIT1: begin
          if (!sw_s) begin
            state_q <= ZERO;
          end else if (bus_if.tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ONE;
`ifdef DEBOUNCE_EDGE_EN
              rise_q  <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ONE: begin
          if (!sw_s) begin
            state_q <= WAIT0;
            cnt_q   <= '0;
          end
        end
        WAIT0: begin
          if (sw_s) begin
            state_q <= ONE;
          end else if (bus_if.tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ZERO;
`ifdef DEBOUNCE_EDGE_EN
              fall_q  <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ZERO;
      endcase
    end
  end

  assign bus_if.db = state_level(state_q);
`ifdef DEBOUNCE_EDGE_EN
  assign bus_if.db_rise = rise_q;
  assign bus_if.db_fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm: directed scenarios plus randomized
// switch/tick traffic compared every cycle against a run-length reference model.
module tb_debounce_fsm;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debounce_fsm_if bus ();

  debounce_fsm #(.N_TICKS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: db follows sw_s once sw_s has differed from db for an unbroken
  // run containing N ticks, the tick on the run's first cycle not counting.
  logic m_s1, m_s2, m_db, m_rise, m_fall;
  bit   m_in_run;
  int   m_ticks;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0;
      m_in_run = 1'b0; m_ticks = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s2 != m_db) begin
        if (!m_in_run) begin
          m_in_run = 1'b1;
          m_ticks  = 0;
        end else if (bus.tick) begin
          m_ticks++;
          if (m_ticks == N) begin
            m_db     = ~m_db;
            m_rise   = m_db;
            m_fall   = ~m_db;
            m_in_run = 1'b0;
          end
        end
      end else begin
        m_in_run = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = bus.sw;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("db", bus.db, m_db);
`ifdef DEBOUNCE_EDGE_EN
      chk("db_rise", bus.db_rise, m_rise);
      chk("db_fall", bus.db_fall, m_fall);
      chk("pulse_excl", bus.db_rise & bus.db_fall, 1'b0);
`endif
    end
  end

  int cyc   = 0;
  int tmode = 0;  // 0: tick every 4th cycle, 1: random tick, 2: tick supplied by caller

  task automatic step(input logic s, input logic t_man);
    @(posedge clk);
    #1;
    cyc++;
    bus.sw = s;
    case (tmode)
      0:       bus.tick = (cyc % 4 == 0);
      1:       bus.tick = 1'($urandom_range(0, 1));
      default: bus.tick = t_man;
    endcase
  endtask

  initial begin
    bit seen;
    logic lvl;
    int   hold;

    reset    = 1'b1;
    bus.sw   = 1'b1;
    bus.tick = 1'b0;

    // Reset held three cycles with the switch pressed
    step(1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_db", bus.db, 1'b0);
    reset = 1'b0;
    repeat (20) step(1'b1, 1'b0);
    chk("rst_then_rise", bus.db, 1'b1);

    // Clean release then clean press
    repeat (20) step(1'b0, 1'b0);
    chk("clean_release", bus.db, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    chk("clean_press", bus.db, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Bounce: toggle every 2 cycles, db must never rise
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(logic'((i / 2) % 2 == 0), 1'b0);
      if (bus.db) seen = 1'b1;
    end
    repeat (10) begin
      step(1'b0, 1'b0);
      if (bus.db) seen = 1'b1;
    end
    chk("bounce_db_high", seen, 1'b0);

    // Short press aborted during WAIT1, then full press
    repeat (8) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("abort_wait1", bus.db, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    chk("press_after_abort", bus.db, 1'b1);

    // Bounce back to 1 on the same edge as the terminal tick in WAIT0
    tmode = 2;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("simul_db", bus.db, 1'b1);
`ifdef DEBOUNCE_EDGE_EN
    chk("simul_fall", bus.db_fall, 1'b0);
`endif
    repeat (6) step(1'b1, 1'b0);
    chk("simul_hold", bus.db, 1'b1);

    // Reset while in WAIT0 with db high
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("pre_rst_db", bus.db, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b0);
    chk("rst_wait0_db", bus.db, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    chk("rst_wait0_fall", bus.db_fall, 1'b0);
`endif
    reset = 1'b0;
    repeat (5) step(1'b0, 1'b0);

    // Randomized traffic: held levels of random length, mixed tick modes, rare resets
    for (int blk = 0; blk < 400; blk++) begin
      tmode = (blk % 2 == 0) ? 0 : 1;
      lvl   = 1'($urandom_range(0, 1));
      hold  = int'($urandom_range(1, 18));
      for (int j = 0; j < hold; j++) begin
        reset = ($urandom_range(0, 199) == 0);
        step(lvl, 1'b0);
      end
    end
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
